// File: rtl/display_arbiter_if.sv
// Row-write request bus between the two writers and the LED frame arbiter,
// plus the scanned matrix outputs.
interface display_arbiter_if;
  logic       clr;
  logic       a_strobe;
  logic [2:0] a_row;
  logic [7:0] a_val;
  logic       b_strobe;
  logic [2:0] b_row;
  logic [7:0] b_val;
  logic       a_busy;
  logic       b_busy;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_start;

  modport master (
    output clr, a_strobe, a_row, a_val, b_strobe, b_row, b_val,
    input  a_busy, b_busy, row_sel, col_data, frame_start
  );

  modport slave (
    input  clr, a_strobe, a_row, a_val, b_strobe, b_row, b_val,
    output a_busy, b_busy, row_sel, col_data, frame_start
  );
endinterface

// File: rtl/display_arbiter.sv
// 8x8 LED frame buffer shared by two row writers (round-robin, one commit per
// cycle) with a continuous one-row-at-a-time scan-out.
module display_arbiter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  display_arbiter_if.slave   bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic {PORT_A, PORT_B} port_e;

  logic [7:0]    buf_q [8];
  logic [7:0]    buf_d [8];
  logic          a_vld_q, a_vld_d;
  logic [2:0]    a_row_q, a_row_d;
  logic [7:0]    a_val_q, a_val_d;
  logic          b_vld_q, b_vld_d;
  logic [2:0]    b_row_q, b_row_d;
  logic [7:0]    b_val_q, b_val_d;
  port_e         last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    scan_row_q, scan_row_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          frame_start_q, frame_start_d;
  logic          grant_a, grant_b, wrap;

  always_comb begin
    buf_d         = buf_q;
    a_vld_d       = a_vld_q;
    a_row_d       = a_row_q;
    a_val_d       = a_val_q;
    b_vld_d       = b_vld_q;
    b_row_d       = b_row_q;
    b_val_d       = b_val_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    scan_row_d    = scan_row_q;
    row_sel_d     = row_sel_q;
    col_data_d    = col_data_q;
    frame_start_d = 1'b0;

    grant_a = a_vld_q && (!b_vld_q || last_q == PORT_B);
    grant_b = b_vld_q && !grant_a;

    if (grant_a) begin
      buf_d[a_row_q] = a_val_q;
      a_vld_d        = 1'b0;
      last_d         = PORT_A;
    end else if (grant_b) begin
      buf_d[b_row_q] = b_val_q;
      b_vld_d        = 1'b0;
      last_d         = PORT_B;
    end

    // A fresh strobe refills the slot even while its old contents commit.
    if (bus.a_strobe) begin
      a_vld_d = 1'b1;
      a_row_d = bus.a_row;
      a_val_d = bus.a_val;
    end
    if (bus.b_strobe) begin
      b_vld_d = 1'b1;
      b_row_d = bus.b_row;
      b_val_d = bus.b_val;
    end

    if (bus.clr) begin
      for (int unsigned i = 0; i < 8; i++) buf_d[i] = '0;
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
      last_d  = PORT_B;
    end

    wrap = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    // Row load reads the pre-edge buffer, so same-edge writes show next scan.
    if (wrap) begin
      scan_row_d    = scan_row_q + 3'd1;
      row_sel_d     = 8'b1 << scan_row_d;
      col_data_d    = buf_q[scan_row_d];
      frame_start_d = (scan_row_d == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q         <= '{default: '0};
      a_vld_q       <= 1'b0;
      a_row_q       <= '0;
      a_val_q       <= '0;
      b_vld_q       <= 1'b0;
      b_row_q       <= '0;
      b_val_q       <= '0;
      last_q        <= PORT_B;
      cnt_q         <= '0;
      scan_row_q    <= '0;
      row_sel_q     <= 8'h01;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      a_vld_q       <= a_vld_d;
      a_row_q       <= a_row_d;
      a_val_q       <= a_val_d;
      b_vld_q       <= b_vld_d;
      b_row_q       <= b_row_d;
      b_val_q       <= b_val_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      scan_row_q    <= scan_row_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.a_busy      = a_vld_q;
  assign bus.b_busy      = b_vld_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.col_data    = col_data_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and random stimulus for display_arbiter, checked every cycle
// against a behavioural frame-buffer/scan model.
module tb_display_arbiter;
  localparam int SD = 4;

  logic clk;
  logic reset;
  display_arbiter_if bus();

  display_arbiter #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: index 0 = port A, 1 = port B.
  int       t;
  int       last;
  bit       pv [2];
  int       pr [2];
  int       pd [2];
  int       mbuf [8];
  int       mcol;
  bit       mfs;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; last = 1; mcol = 0; mfs = 0;
    pv[0] = 0; pv[1] = 0;
    for (int i = 0; i < 8; i++) mbuf[i] = 0;
  endtask

  task automatic model_edge();
    int g;
    bit st [2];
    int sr [2];
    int sv [2];
    st[0] = bus.a_strobe; sr[0] = bus.a_row; sv[0] = bus.a_val;
    st[1] = bus.b_strobe; sr[1] = bus.b_row; sv[1] = bus.b_val;
    t++;
    mfs = (t % (8 * SD) == 0);
    if (t % SD == 0) mcol = mbuf[(t / SD) % 8];
    if (bus.clr) begin
      for (int i = 0; i < 8; i++) mbuf[i] = 0;
      pv[0] = 0; pv[1] = 0; last = 1;
    end else begin
      g = -1;
      if (pv[0] && pv[1]) g = 1 - last;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
      if (g >= 0) begin
        mbuf[pr[g]] = pd[g];
        pv[g] = 0;
        last = g;
      end
      for (int p = 0; p < 2; p++)
        if (st[p]) begin pv[p] = 1; pr[p] = sr[p]; pd[p] = sv[p]; end
    end
  endtask

  task automatic check_all();
    chk("a_busy",      8'(bus.a_busy), 8'(pv[0]));
    chk("b_busy",      8'(bus.b_busy), 8'(pv[1]));
    chk("row_sel",     bus.row_sel, 8'(1 << ((t / SD) % 8)));
    chk("col_data",    bus.col_data, 8'(mcol));
    chk("frame_start", 8'(bus.frame_start), 8'(mfs));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.clr = 0; bus.a_strobe = 0; bus.b_strobe = 0;
    bus.a_row = 0; bus.a_val = 0; bus.b_row = 0; bus.b_val = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #2 reset = 0;
    model_reset();
    #1;
    chk("reset_row_sel", bus.row_sel, 8'h01);
    chk("reset_col", bus.col_data, 8'h00);
    check_all();
    @(negedge clk);
    reset = 1;

    // Idle scan: full frame and wrap.
    run(34);

    // Single A write to row 3.
    bus.a_strobe = 1; bus.a_row = 3; bus.a_val = 8'hE0;
    tick();
    idle_inputs();
    chk("a_busy_one_cycle", 8'(bus.a_busy), 8'h01);
    tick();
    chk("a_busy_drop", 8'(bus.a_busy), 8'h00);
    run(40);

    // Same-row tie after reset: A first, then B.
    do_reset();
    bus.a_strobe = 1; bus.a_row = 1; bus.a_val = 8'h0F;
    bus.b_strobe = 1; bus.b_row = 1; bus.b_val = 8'hF0;
    tick();
    idle_inputs();
    tick();
    chk("tie_a_first", {6'b0, bus.a_busy, bus.b_busy}, 8'h01);
    tick();
    chk("tie_b_next", {6'b0, bus.a_busy, bus.b_busy}, 8'h00);
    run(40);

    // Both ports strobing six cycles in a row.
    for (int i = 0; i < 6; i++) begin
      bus.a_strobe = 1; bus.a_row = 3'(i);     bus.a_val = 8'(8'h10 + i);
      bus.b_strobe = 1; bus.b_row = 3'(7 - i); bus.b_val = 8'(8'hA0 + i);
      tick();
    end
    idle_inputs();
    run(40);

    // Clear racing a B strobe, then a tie must grant A.
    bus.a_strobe = 1; bus.a_row = 2; bus.a_val = 8'hFF;
    tick();
    idle_inputs();
    run(2);
    bus.clr = 1; bus.b_strobe = 1; bus.b_row = 5; bus.b_val = 8'h3C;
    tick();
    idle_inputs();
    chk("clr_b_busy", 8'(bus.b_busy), 8'h00);
    run(36);
    bus.a_strobe = 1; bus.a_row = 4; bus.a_val = 8'h55;
    bus.b_strobe = 1; bus.b_row = 6; bus.b_val = 8'h66;
    tick();
    idle_inputs();
    tick();
    chk("post_clr_tie_a", {6'b0, bus.a_busy, bus.b_busy}, 8'h01);
    run(36);

    // Random traffic with occasional clear.
    for (int i = 0; i < 400; i++) begin
      bus.a_strobe = ($urandom_range(0, 2) == 0);
      bus.a_row    = 3'($urandom);
      bus.a_val    = 8'($urandom);
      bus.b_strobe = ($urandom_range(0, 2) == 0);
      bus.b_row    = 3'($urandom);
      bus.b_val    = 8'($urandom);
      bus.clr      = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle_inputs();
    run(40);

    // Asynchronous reset while a write is pending on row 5's scan slot.
    do_reset();
    run(20);
    bus.a_strobe = 1; bus.a_row = 0; bus.a_val = 8'h99;
    tick();
    idle_inputs();
    chk("pre_rst_busy", 8'(bus.a_busy), 8'h01);
    chk("pre_rst_row", bus.row_sel, 8'h20);
    #2 reset = 0;
    model_reset();
    #1;
    chk("async_rst_busy", 8'(bus.a_busy), 8'h00);
    chk("async_rst_row", bus.row_sel, 8'h01);
    check_all();
    @(negedge clk);
    reset = 1;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
